// File: rtl/immediate_formatter_pkg.sv
// ---------------------------------------------------------------------------
// assembler_constants
// Shared definitions for the assembler/disassembler character path:
//   QUOTE_CHAR      - ASCII single quote that brackets every immediate
//   NIBBLE_MSB_IDX  - index of the most significant nibble of a 32-bit value
//   fmt_state_e     - immediate formatter state encoding
//   hex_to_ascii()  - nibble to uppercase ASCII hex digit
//   nibble_at()     - select one nibble of a 32-bit value by index
// ---------------------------------------------------------------------------
package assembler_constants;

  localparam logic [7:0] QUOTE_CHAR     = 8'h27;
  localparam logic [2:0] NIBBLE_MSB_IDX = 3'd7;

  typedef enum logic [2:0] {
    IDLE,
    OPEN,
    DIGITS,
    CLOSE,
    DONE
  } fmt_state_e;

  // 0-9 land on '0'..'9' (0x30..), 10-15 land on 'A'..'F' (0x41..)
  function automatic logic [7:0] hex_to_ascii(input logic [3:0] nibble);
    if (nibble < 4'd10) begin
      return 8'h30 + {4'h0, nibble};
    end
    return 8'h37 + {4'h0, nibble};
  endfunction

  function automatic logic [3:0] nibble_at(input logic [31:0] value,
                                           input logic [2:0]  idx);
    return value[{idx, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/leading_nibble_finder.sv
// ---------------------------------------------------------------------------
// leading_nibble_finder
// Combinational search for the most significant nonzero nibble of a word.
// Used by immediate_formatter only when IMM_FORMATTER_ZERO_SUPPRESS_EN is
// defined.
// Ports:
//   value_i  [31:0]  word to inspect
//   index_o  [2:0]   index of highest nonzero nibble, 0 when value_i is 0
// ---------------------------------------------------------------------------
module leading_nibble_finder (
  input  logic [31:0] value_i,
  output logic [2:0]  index_o
);

  // Ascending scan: the last nonzero nibble seen is the highest one.
  always_comb begin
    index_o = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (value_i[i*4 +: 4] != 4'h0) begin
        index_o = 3'(i);
      end
    end
  end

endmodule

// File: rtl/immediate_formatter.sv
// ---------------------------------------------------------------------------
// immediate_formatter
// Turns a 32-bit immediate into the quoted-hex character stream accepted by
// the assembler's immediate parser: quote, hex digits MSB first, quote.
// One value per transaction, one character per downstream handshake.
//
// Configuration macro: IMM_FORMATTER_ZERO_SUPPRESS_EN
//   defined   - leading zero digits are skipped (value 0 still emits '0')
//   undefined - exactly 8 digits are always emitted
//
// Ports:
//   clk_in           system clock
//   rst_in           asynchronous active-high reset
//   valid_in         upstream offers immediate_in
//   immediate_in     value to format, sampled on accept
//   ready_out        block can accept (IDLE and not in reset)
//   ascii_out        current character (registered)
//   ascii_valid_out  ascii_out is valid (registered)
//   ascii_ready_in   downstream consumes ascii_out
//   busy_flag        high in any state other than IDLE
//   done_flag        one-cycle pulse after the closing quote is consumed
// ---------------------------------------------------------------------------
module immediate_formatter
  import assembler_constants::*;
(
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        valid_in,
  input  logic [31:0] immediate_in,
  output logic        ready_out,
  output logic [7:0]  ascii_out,
  output logic        ascii_valid_out,
  input  logic        ascii_ready_in,
  output logic        busy_flag,
  output logic        done_flag
);

  fmt_state_e  state_q;
  logic [31:0] value_q;
  logic [2:0]  idx_q;
  logic [7:0]  ascii_q;
  logic        ascii_valid_q;
  logic        done_q;

  logic [2:0]  start_idx_d;
  logic        handshake;

  assign handshake = ascii_valid_q & ascii_ready_in;

  // First digit index used when leaving OPEN.
`ifdef IMM_FORMATTER_ZERO_SUPPRESS_EN
  leading_nibble_finder u_leading_nibble_finder (
    .value_i (value_q),
    .index_o (start_idx_d)
  );
`else
  assign start_idx_d = NIBBLE_MSB_IDX;
`endif

  // Character is loaded one edge ahead of the state that presents it, so
  // ascii_out/ascii_valid_out stay registered and simply hold while the
  // downstream stalls.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q       <= IDLE;
      value_q       <= 32'h0;
      idx_q         <= 3'd0;
      ascii_q       <= 8'h00;
      ascii_valid_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // ready_out is implied here: IDLE and reset released
          if (valid_in) begin
            value_q       <= immediate_in;
            idx_q         <= NIBBLE_MSB_IDX;
            ascii_q       <= QUOTE_CHAR;
            ascii_valid_q <= 1'b1;
            state_q       <= OPEN;
          end
        end
        OPEN: begin
          if (handshake) begin
            idx_q   <= start_idx_d;
            ascii_q <= hex_to_ascii(nibble_at(value_q, start_idx_d));
            state_q <= DIGITS;
          end
        end
        DIGITS: begin
          if (handshake) begin
            if (idx_q == 3'd0) begin
              ascii_q <= QUOTE_CHAR;
              state_q <= CLOSE;
            end else begin
              idx_q   <= idx_q - 3'd1;
              ascii_q <= hex_to_ascii(nibble_at(value_q, idx_q - 3'd1));
            end
          end
        end
        CLOSE: begin
          if (handshake) begin
            ascii_q       <= 8'h00;
            ascii_valid_q <= 1'b0;
            done_q        <= 1'b1;
            state_q       <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          ascii_valid_q <= 1'b0;
          state_q       <= IDLE;
        end
      endcase
    end
  end

  assign ready_out       = (state_q == IDLE) && !rst_in;
  assign busy_flag       = (state_q != IDLE);
  assign ascii_out       = ascii_q;
  assign ascii_valid_out = ascii_valid_q;
  assign done_flag       = done_q;

endmodule
